// File: rtl/clkratio_pkg.sv
// Shared definitions for the clock-ratio detector: FSM encoding and default sizing.
package clkratio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int DEF_CNT_W    = 4;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_TIMEOUT  = 15;

  // Wide enough for the full legal LOCK_CNT range (1..15).
  localparam int MATCH_W = 4;

endpackage

// File: rtl/clkratio_sync.sv
// Sampling front end plus rising-edge detect for the measured clock.
// CLKRATIO_SYNC2_EN adds a metastability flop ahead of the edge register.
module clkratio_sync
  import clkratio_pkg::*;
(
  input  logic clkin,
  input  logic rstn,
  input  logic i_meas,
  output logic o_edge
);

  logic r_s_q;
  logic r_s_qq;

`ifdef CLKRATIO_SYNC2_EN
  logic r_meta;

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_meta <= 1'b0;
      r_s_q  <= 1'b0;
      r_s_qq <= 1'b0;
    end else begin
      r_meta <= i_meas;
      r_s_q  <= r_meta;
      r_s_qq <= r_s_q;
    end
  end
`else
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_s_q  <= 1'b0;
      r_s_qq <= 1'b0;
    end else begin
      r_s_q  <= i_meas;
      r_s_qq <= r_s_q;
    end
  end
`endif

  assign o_edge = r_s_q & ~r_s_qq;

endmodule

// File: rtl/clkratio_det.sv
// Clock-ratio detector: measures clk_meas rising-edge period in clkin cycles and
// locks after LOCK_CNT equal periods. Front end depth set by CLKRATIO_SYNC2_EN.
module clkratio_det
  import clkratio_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clkin,
  input  logic             rstn,
  input  logic             clk_meas,
  input  logic             clear,
  output logic [CNT_W-1:0] ratio,
  output logic             locked,
  output logic             valid,
  output logic             err
);

  localparam logic [CNT_W-1:0]   TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   TO_ARM  = CNT_W'(TIMEOUT - 1);
  localparam logic [MATCH_W-1:0] LOCK_V  = MATCH_W'(LOCK_CNT);
  localparam logic [MATCH_W-1:0] LOCK_M1 = MATCH_W'(LOCK_CNT - 1);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [CNT_W-1:0]   r_ref, w_ref_next;
  logic [CNT_W-1:0]   r_ratio;
  logic [MATCH_W-1:0] r_match, w_match_next;
  logic               r_err, w_err_next;
  logic               r_locked;
  logic               r_valid, w_valid_next;
  logic               w_edge;
  logic               w_same;
  logic               w_timeout;

  clkratio_sync u_sync (
    .clkin  (clkin),
    .rstn   (rstn),
    .i_meas (clk_meas),
    .o_edge (w_edge)
  );

  // r_cnt still holds the finished period on the cycle the edge is seen.
  assign w_same    = (r_cnt == r_ref);
  assign w_timeout = (r_state != ST_IDLE) && (r_cnt >= TO_ARM);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ref_next   = r_ref;
    w_match_next = r_match;
    w_err_next   = r_err;
    w_valid_next = 1'b0;
    if (clear) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_ref_next   = '0;
      w_match_next = '0;
      w_err_next   = 1'b0;
    end else if (w_edge) begin
      w_cnt_next = CNT_W'(1);
      case (r_state)
        ST_IDLE: w_state_next = ST_FIRST;
        ST_FIRST: begin
          w_ref_next   = r_cnt;
          w_match_next = MATCH_W'(1);
          if (LOCK_CNT == 1) begin
            w_state_next = ST_LOCKED;
            w_valid_next = 1'b1;
          end else begin
            w_state_next = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (w_same) begin
            w_match_next = (r_match >= LOCK_V) ? LOCK_V : r_match + 1'b1;
            if (r_match >= LOCK_M1) begin
              w_state_next = ST_LOCKED;
              w_valid_next = 1'b1;
            end
          end else begin
            w_ref_next   = r_cnt;
            w_match_next = MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          if (!w_same) begin
            w_err_next   = 1'b1;
            w_ref_next   = r_cnt;
            w_match_next = MATCH_W'(1);
            w_state_next = ST_TRACK;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end else begin
      w_cnt_next = (r_cnt >= TO_VAL) ? TO_VAL : r_cnt + 1'b1;
      if (w_timeout) begin
        w_state_next = ST_IDLE;
        w_ref_next   = '0;
        w_match_next = '0;
      end
    end
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ref    <= '0;
      r_match  <= '0;
      r_err    <= 1'b0;
      r_ratio  <= '0;
      r_locked <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_ref    <= w_ref_next;
      r_match  <= w_match_next;
      r_err    <= w_err_next;
      r_ratio  <= (w_state_next == ST_LOCKED) ? w_ref_next : '0;
      r_locked <= (w_state_next == ST_LOCKED);
      r_valid  <= w_valid_next;
    end
  end

  assign ratio  = r_ratio;
  assign locked = r_locked;
  assign valid  = r_valid;
  assign err    = r_err;

endmodule

// File: tb/tb_clkratio_det.sv
// Scoreboard bench for clkratio_det: stimulus queues expected output changes
// with their arrival cycle; a monitor compares every observed output change.
module tb_clkratio_det;
  import clkratio_pkg::*;

  localparam int TIMEOUT = 15;
`ifdef CLKRATIO_SYNC2_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic       clkin    = 1'b0;
  logic       rstn     = 1'b1;
  logic       clk_meas = 1'b0;
  logic       clear    = 1'b0;
  logic [3:0] ratio;
  logic       locked;
  logic       valid;
  logic       err;

  int cyc         = 0;
  int n_cmp       = 0;
  int n_bad       = 0;
  int clear_at    = -1;
  int idle_chk_at = -1;

  typedef struct {
    logic [6:0] val;
    int         at;
    string      nm;
  } exp_t;

  exp_t exp_q[$];

  clkratio_det #(.CNT_W(4), .LOCK_CNT(4), .TIMEOUT(TIMEOUT)) dut (
    .clkin    (clkin),
    .rstn     (rstn),
    .clk_meas (clk_meas),
    .clear    (clear),
    .ratio    (ratio),
    .locked   (locked),
    .valid    (valid),
    .err      (err)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [6:0] act, input logic [6:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  task automatic expect_ev(input string nm, input logic [3:0] r, input logic l,
                           input logic v, input logic e, input int at);
    exp_t x;
    x.val = {r, l, v, e};
    x.at  = at;
    x.nm  = nm;
    exp_q.push_back(x);
  endtask

  task automatic step(input logic m);
    @(negedge clkin);
    clk_meas = m;
    clear    = (cyc == clear_at);
    if (cyc == idle_chk_at)
      check("idle_after_clear", {5'd0, dut.r_state}, {5'd0, ST_IDLE});
  endtask

  // One clk_meas period: rises on its first step, high for h cycles.
  task automatic period(input int p, input int h);
    for (int i = 0; i < p; i++) step(i < h);
  endtask

  task automatic lock_then_stop(input string nm, input int p, input int h, input logic [3:0] r);
    int nr;
    nr = 0;
    for (int k = 1; k <= 7; k++) begin
      nr = cyc + 1;
      if (k == 5) begin
        expect_ev({nm, "_lock"}, r, 1'b1, 1'b1, 1'b0, nr + LAT);
        expect_ev({nm, "_valid_end"}, r, 1'b1, 1'b0, 1'b0, nr + LAT + 1);
      end
      period(p, h);
    end
    expect_ev({nm, "_timeout"}, 4'd0, 1'b0, 1'b0, 1'b0, nr + LAT + TIMEOUT - 1);
    repeat (TIMEOUT + 6) step(1'b0);
  endtask

  // Monitor: every change on the outputs must match the next queued expectation.
  initial begin
    logic [6:0] prev;
    logic [6:0] cur;
    exp_t       x;
    prev = '0;
    forever begin
      @(negedge clkin);
      cur = {ratio, locked, valid, err};
      if (cur !== prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got %h at cycle %0d, want no change", cur, cyc);
        end else begin
          x = exp_q.pop_front();
          if (cur !== x.val || cyc != x.at) begin
            n_bad++;
            $display("FAIL %s: got %h at cycle %0d, want %h at cycle %0d",
                     x.nm, cur, cyc, x.val, x.at);
          end else begin
            $display("event %s: ratio=%0d locked=%b valid=%b err=%b at cycle %0d",
                     x.nm, ratio, locked, valid, err, cyc);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int nr;
    nr = 0;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clkin);
    check("reset_outputs", {ratio, locked, valid, err}, 7'd0);
    check("reset_state", {5'd0, dut.r_state}, {5'd0, ST_IDLE});
    #2 rstn = 1'b1;

    lock_then_stop("div2", 2, 1, 4'd2);
    lock_then_stop("div3", 3, 1, 4'd3);

    // Lock at /4, switch to /3: error, relock, then clear on an edge.
    for (int k = 1; k <= 7; k++) begin
      nr = cyc + 1;
      if (k == 5) begin
        expect_ev("div4_lock", 4'd4, 1'b1, 1'b1, 1'b0, nr + LAT);
        expect_ev("div4_valid_end", 4'd4, 1'b1, 1'b0, 1'b0, nr + LAT + 1);
      end
      period(4, 2);
    end
    for (int k = 1; k <= 11; k++) begin
      nr = cyc + 1;
      case (k)
        2: expect_ev("div3_mismatch", 4'd0, 1'b0, 1'b0, 1'b1, nr + LAT);
        5: begin
          expect_ev("div3_relock", 4'd3, 1'b1, 1'b1, 1'b1, nr + LAT);
          expect_ev("div3_relock_vend", 4'd3, 1'b1, 1'b0, 1'b1, nr + LAT + 1);
        end
        6: begin
          clear_at    = nr + LAT - 1;
          idle_chk_at = nr + LAT + 1;
          expect_ev("clear_on_edge", 4'd0, 1'b0, 1'b0, 1'b0, nr + LAT);
        end
        11: begin
          expect_ev("after_clear_lock", 4'd3, 1'b1, 1'b1, 1'b0, nr + LAT);
          expect_ev("after_clear_vend", 4'd3, 1'b1, 1'b0, 1'b0, nr + LAT + 1);
        end
        default: ;
      endcase
      period(3, 1);
    end

    // Move to /5 to get err=1 in TRACK, then reset asynchronously.
    for (int k = 1; k <= 3; k++) begin
      nr = cyc + 1;
      if (k == 2) expect_ev("div5_mismatch", 4'd0, 1'b0, 1'b0, 1'b1, nr + LAT);
      period(5, 2);
    end
    #2 rstn = 1'b0;
    #1;
    check("async_reset_outputs", {ratio, locked, valid, err}, 7'd0);
    check("async_reset_state", {5'd0, dut.r_state}, {5'd0, ST_IDLE});
    expect_ev("async_reset_seen", 4'd0, 1'b0, 1'b0, 1'b0, cyc + 1);
    repeat (3) step(1'b0);
    rstn = 1'b1;

    lock_then_stop("post_reset", 2, 1, 4'd2);

    repeat (5) step(1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d outstanding, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
